zap_fetch_fifo: RTL and testbench

Elastic instruction buffer sitting directly downstream of the fetch stage and upstream of decode. Captures fetch-stage output packets (instruction, PC, PC+8, abort, branch prediction) into a small flop-based FIFO. Presents the oldest packet to decode in first-word-fall-through fashion. Decouples decode/issue stalls from fetch, and raises an almost-full stall back to fetch so that the one packet still in flight is always absorbed.

---
 rtl/zap_fetch_fifo.sv | 131 +++++++++++++
 tb/tb_zap_fetch_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/zap_fetch_fifo.sv
// Purpose : elastic fetch->decode instruction buffer, flop-based FIFO with first-word-fall-through head.
// Latency : 1 cycle push-to-head (no bypass); head is driven straight from storage flops.
// Backpres: o_stall_to_fetch asserts at DEPTH-1 entries so the packet already in flight still fits;
//           i_stall_downstream holds the head in place.
//
// Ports:
//   i_clk, i_reset               clock and synchronous active-high reset
//   i_clear_from_{writeback,alu,decode}  pipeline flushes; any one empties the buffer
//   i_stall_downstream           decode/issue cannot take the head this cycle
//   i_valid + packet fields      push request from fetch (instruction, abort, pc, pc+8, taken)
//   o_stall_to_fetch             almost-full indication back to fetch
//   o_overflow                   registered pulse when a push was dropped against a full buffer
//   o_valid + packet fields      oldest buffered packet

module zap_fetch_fifo #(
    parameter int DEPTH = 4             // power of 2, >= 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear_from_writeback,
    input  logic        i_clear_from_alu,
    input  logic        i_clear_from_decode,
    input  logic        i_stall_downstream,
    input  logic        i_valid,
    input  logic [31:0] i_instruction,
    input  logic        i_instr_abort,
    input  logic [31:0] i_pc_ff,
    input  logic [31:0] i_pc_plus_8_ff,
    input  logic [1:0]  i_taken,
    output logic        o_stall_to_fetch,
    output logic        o_overflow,
    output logic        o_valid,
    output logic [31:0] o_instruction,
    output logic        o_instr_abort,
    output logic [31:0] o_pc_ff,
    output logic [31:0] o_pc_plus_8_ff,
    output logic [1:0]  o_taken
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1_C = CW'(DEPTH - 1);

    // One buffered fetch packet (99 bits).
    typedef struct packed {
        logic [31:0] instruction;
        logic        instr_abort;
        logic [31:0] pc;
        logic [31:0] pc_plus_8;
        logic [1:0]  taken;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          wr_entry;
    entry_t          head;

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            overflow_q, overflow_d;

    logic            flush;
    logic            full;
    logic            pop_vld;
    logic            push_vld;

    assign wr_entry = '{
        instruction: i_instruction,
        instr_abort: i_instr_abort,
        pc:          i_pc_ff,
        pc_plus_8:   i_pc_plus_8_ff,
        taken:       i_taken
    };

    always_comb begin
        flush      = i_clear_from_writeback | i_clear_from_alu | i_clear_from_decode;
        full       = (count_q == DEPTH_C);
        pop_vld    = (count_q != '0) && !i_stall_downstream && !flush;
        // A full buffer still accepts a push when the head leaves in the same cycle.
        push_vld   = i_valid && !flush && (!full || pop_vld);
        overflow_d = i_valid && !flush && full && !pop_vld;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of 2.
            wr_ptr_d = wr_ptr_q + AW'(push_vld);
            rd_ptr_d = rd_ptr_q + AW'(pop_vld);
            count_d  = count_q + CW'(push_vld) - CW'(pop_vld);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; o_valid qualifies the head.
    always_ff @(posedge i_clk) begin
        if (push_vld) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign head             = mem_q[rd_ptr_q];
    assign o_valid          = (count_q != '0);
    assign o_stall_to_fetch = (count_q >= DEPTH_M1_C);
    assign o_overflow       = overflow_q;
    assign o_instruction    = head.instruction;
    assign o_instr_abort    = head.instr_abort;
    assign o_pc_ff          = head.pc;
    assign o_pc_plus_8_ff   = head.pc_plus_8;
    assign o_taken          = head.taken;

endmodule

// File: tb/tb_zap_fetch_fifo.sv
// Bench for zap_fetch_fifo: directed vector table followed by a randomized run
// checked against a queue-based reference model.

module tb_zap_fetch_fifo;

    localparam int DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_clear_from_writeback;
    logic        i_clear_from_alu;
    logic        i_clear_from_decode;
    logic        i_stall_downstream;
    logic        i_valid;
    logic [31:0] i_instruction;
    logic        i_instr_abort;
    logic [31:0] i_pc_ff;
    logic [31:0] i_pc_plus_8_ff;
    logic [1:0]  i_taken;
    logic        o_stall_to_fetch;
    logic        o_overflow;
    logic        o_valid;
    logic [31:0] o_instruction;
    logic        o_instr_abort;
    logic [31:0] o_pc_ff;
    logic [31:0] o_pc_plus_8_ff;
    logic [1:0]  o_taken;

    zap_fetch_fifo #(.DEPTH(DEPTH)) dut (
        .i_clk                  (i_clk),
        .i_reset                (i_reset),
        .i_clear_from_writeback (i_clear_from_writeback),
        .i_clear_from_alu       (i_clear_from_alu),
        .i_clear_from_decode    (i_clear_from_decode),
        .i_stall_downstream     (i_stall_downstream),
        .i_valid                (i_valid),
        .i_instruction          (i_instruction),
        .i_instr_abort          (i_instr_abort),
        .i_pc_ff                (i_pc_ff),
        .i_pc_plus_8_ff         (i_pc_plus_8_ff),
        .i_taken                (i_taken),
        .o_stall_to_fetch       (o_stall_to_fetch),
        .o_overflow             (o_overflow),
        .o_valid                (o_valid),
        .o_instruction          (o_instruction),
        .o_instr_abort          (o_instr_abort),
        .o_pc_ff                (o_pc_ff),
        .o_pc_plus_8_ff         (o_pc_plus_8_ff),
        .o_taken                (o_taken)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        vld;
        logic        stall;
        logic [2:0]  clr;       // {writeback, alu, decode}
        logic [31:0] pc;
        logic        abort;
        logic [1:0]  taken;
        logic        e_vld;
        logic        e_stf;
        logic        e_ovf;
        logic [31:0] e_pc;
        logic        e_abort;
        logic [1:0]  e_taken;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        abort;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [1:0]  taken;
    } pkt_t;

    vec_t vecs[$];
    pkt_t model_q[$];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        case (pc)
            32'h0:   return 32'hE1A00000;
            32'h4:   return 32'hE2811001;
            32'h8:   return 32'hE2822002;
            default: return 32'hE3A00000 | pc;
        endcase
    endfunction

    function automatic vec_t mk(input logic vld, input logic stall, input logic [2:0] clr,
                                input logic [31:0] pc, input logic e_vld, input logic e_stf,
                                input logic e_ovf, input logic [31:0] e_pc);
        vec_t v;
        v.vld = vld;  v.stall = stall; v.clr = clr; v.pc = pc;
        v.abort = 1'b0; v.taken = 2'b00;
        v.e_vld = e_vld; v.e_stf = e_stf; v.e_ovf = e_ovf; v.e_pc = e_pc;
        v.e_abort = 1'b0; v.e_taken = 2'b00;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic stall, input logic [2:0] clr,
                         input logic [31:0] instr, input logic abort, input logic [31:0] pc,
                         input logic [31:0] pc8, input logic [1:0] taken);
        i_valid                = vld;
        i_stall_downstream     = stall;
        i_clear_from_writeback = clr[2];
        i_clear_from_alu       = clr[1];
        i_clear_from_decode    = clr[0];
        i_instruction          = instr;
        i_instr_abort          = abort;
        i_pc_ff                = pc;
        i_pc_plus_8_ff         = pc8;
        i_taken                = taken;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        vec_t v;
        // ---- reset ----
        i_reset = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00);
        i_reset = 1'b0;
        chk("reset o_valid", {31'b0, o_valid}, 32'd0);
        chk("reset o_stall_to_fetch", {31'b0, o_stall_to_fetch}, 32'd0);
        chk("reset o_overflow", {31'b0, o_overflow}, 32'd0);

        // ---- directed table: expected values hold after the edge ----
        // streaming, no stall
        vecs.push_back(mk(1, 0, 3'b000, 32'h0,  1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 3'b000, 32'h4,  1, 0, 0, 32'h4));
        vecs.push_back(mk(1, 0, 3'b000, 32'h8,  1, 0, 0, 32'h8));
        vecs.push_back(mk(0, 0, 3'b000, 32'h0,  0, 0, 0, 32'h0));
        // fill under stall, then overflow attempt
        vecs.push_back(mk(1, 1, 3'b000, 32'h10, 1, 0, 0, 32'h10));
        vecs.push_back(mk(1, 1, 3'b000, 32'h14, 1, 0, 0, 32'h10));
        vecs.push_back(mk(1, 1, 3'b000, 32'h18, 1, 1, 0, 32'h10));
        vecs.push_back(mk(1, 1, 3'b000, 32'h1C, 1, 1, 0, 32'h10));
        vecs.push_back(mk(1, 1, 3'b000, 32'h20, 1, 1, 1, 32'h10));
        vecs.push_back(mk(0, 1, 3'b000, 32'h0,  1, 1, 0, 32'h10));
        // full: pop and push together, then drain
        vecs.push_back(mk(1, 0, 3'b000, 32'h20, 1, 1, 0, 32'h14));
        vecs.push_back(mk(0, 0, 3'b000, 32'h0,  1, 1, 0, 32'h18));
        vecs.push_back(mk(0, 0, 3'b000, 32'h0,  1, 0, 0, 32'h1C));
        vecs.push_back(mk(0, 0, 3'b000, 32'h0,  1, 0, 0, 32'h20));
        vecs.push_back(mk(0, 0, 3'b000, 32'h0,  0, 0, 0, 32'h0));
        // 3 entries then ALU flush with a simultaneous push
        vecs.push_back(mk(1, 1, 3'b000, 32'h40, 1, 0, 0, 32'h40));
        vecs.push_back(mk(1, 1, 3'b000, 32'h44, 1, 0, 0, 32'h40));
        vecs.push_back(mk(1, 1, 3'b000, 32'h48, 1, 1, 0, 32'h40));
        vecs.push_back(mk(1, 0, 3'b010, 32'h4C, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 3'b000, 32'h0,  0, 0, 0, 32'h0));
        // abort packet forwarded untouched
        v = mk(1, 1, 3'b000, 32'h100, 1, 0, 0, 32'h100);
        v.abort = 1'b1; v.taken = 2'b10; v.e_abort = 1'b1; v.e_taken = 2'b10;
        vecs.push_back(v);
        vecs.push_back(mk(0, 0, 3'b000, 32'h0,  0, 0, 0, 32'h0));
        // writeback and decode flushes; flush beats the pop and the push
        vecs.push_back(mk(1, 1, 3'b000, 32'h200, 1, 0, 0, 32'h200));
        vecs.push_back(mk(0, 0, 3'b100, 32'h0,   0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 3'b000, 32'h204, 1, 0, 0, 32'h204));
        vecs.push_back(mk(1, 0, 3'b001, 32'h208, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 3'b000, 32'h0,   0, 0, 0, 32'h0));

        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v.vld, v.stall, v.clr, instr_of(v.pc), v.abort, v.pc, v.pc + 32'd8, v.taken);
            chk($sformatf("vec%0d o_valid", i), {31'b0, o_valid}, {31'b0, v.e_vld});
            chk($sformatf("vec%0d o_stall_to_fetch", i), {31'b0, o_stall_to_fetch}, {31'b0, v.e_stf});
            chk($sformatf("vec%0d o_overflow", i), {31'b0, o_overflow}, {31'b0, v.e_ovf});
            if (v.e_vld) begin
                chk($sformatf("vec%0d o_pc_ff", i), o_pc_ff, v.e_pc);
                chk($sformatf("vec%0d o_instruction", i), o_instruction, instr_of(v.e_pc));
                chk($sformatf("vec%0d o_pc_plus_8_ff", i), o_pc_plus_8_ff, v.e_pc + 32'd8);
                chk($sformatf("vec%0d o_instr_abort", i), {31'b0, o_instr_abort}, {31'b0, v.e_abort});
                chk($sformatf("vec%0d o_taken", i), {30'b0, o_taken}, {30'b0, v.e_taken});
            end
        end

        // ---- randomized run against a queue model (FIFO empty here) ----
        model_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            pkt_t p;
            logic vld, stall, flush, pop, push, exp_ovf;
            logic [2:0] clr;
            vld   = ($urandom_range(0, 9) < 7);
            stall = ($urandom_range(0, 9) < 4);
            clr   = 3'b000;
            if ($urandom_range(0, 29) == 0) clr[$urandom_range(0, 2)] = 1'b1;
            p.instr = $urandom;
            p.abort = 1'($urandom_range(0, 1));
            p.pc    = $urandom & 32'hFFFF_FFFC;
            p.pc8   = p.pc + 32'd8;
            p.taken = 2'($urandom_range(0, 3));

            flush   = (clr != 3'b000);
            pop     = (model_q.size() != 0) && !stall && !flush;
            push    = vld && !flush && (model_q.size() < DEPTH || pop);
            exp_ovf = vld && !flush && (model_q.size() == DEPTH) && !pop;
            if (flush) model_q.delete();
            if (pop)   void'(model_q.pop_front());
            if (push)  model_q.push_back(p);

            drive(vld, stall, clr, p.instr, p.abort, p.pc, p.pc8, p.taken);

            chk($sformatf("rnd%0d o_valid", cyc), {31'b0, o_valid}, {31'b0, model_q.size() != 0});
            chk($sformatf("rnd%0d o_stall_to_fetch", cyc), {31'b0, o_stall_to_fetch},
                {31'b0, model_q.size() >= DEPTH - 1});
            chk($sformatf("rnd%0d o_overflow", cyc), {31'b0, o_overflow}, {31'b0, exp_ovf});
            if (model_q.size() != 0) begin
                chk($sformatf("rnd%0d o_instruction", cyc), o_instruction, model_q[0].instr);
                chk($sformatf("rnd%0d o_pc_ff", cyc), o_pc_ff, model_q[0].pc);
                chk($sformatf("rnd%0d o_pc_plus_8_ff", cyc), o_pc_plus_8_ff, model_q[0].pc8);
                chk($sformatf("rnd%0d o_instr_abort", cyc), {31'b0, o_instr_abort}, {31'b0, model_q[0].abort});
                chk($sformatf("rnd%0d o_taken", cyc), {30'b0, o_taken}, {30'b0, model_q[0].taken});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
